// File: rtl/ccpu_bus_pkg.sv
// Shared types and address-map constants for the CPU bus sequencer and chip-select decoder.
package ccpu_bus_pkg;

  typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_IO} region_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EXT, ST_DONE} state_t;

  localparam logic [7:0]  IO_PAGE     = 8'hFF;
  localparam logic [1:0]  EXT_SEL     = 2'b11;
  localparam int unsigned CR_RAML_BIT = 0;

  // Same precedence as the chip-select decoder: IO page first, then ROM/RAM split.
  function automatic region_t decode_region(input logic [15:0] addr, input logic ram_low);
    if (addr[15:8] == IO_PAGE) return REG_IO;
    if (!addr[15] && !ram_low) return REG_ROM;
    return REG_RAM;
  endfunction

endpackage

// File: rtl/ws_down_counter.sv
// 4-bit loadable down-counter with zero flag; holds at zero rather than wrapping.
module ws_down_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bus_wait_ctrl.sv
// Wait-state sequencer driving the CPU's active-low ready line.
// Optional EXT timeout with sticky bus_err is enabled by defining WS_TIMEOUT_EN.
module bus_wait_ctrl
  import ccpu_bus_pkg::*;
#(
  parameter int unsigned ROM_WS  = 1,
  parameter int unsigned RAM_WS  = 0,
  parameter int unsigned IO_WS   = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        n_oe,
  input  logic        n_we,
  input  logic [7:0]  cr,
  input  logic        ext_rdy,
  input  logic        err_clr,
  output logic        n_rdy,
  output logic        bus_err
);

  state_t      state_q, state_d;
  region_t     region;
  logic        strobe;
  logic        ext_live, ext_q, ext_d;
  logic [3:0]  ws;
  logic        n_rdy_d;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic [3:0]  cnt;

  assign strobe   = ~n_oe | ~n_we;
  assign region   = decode_region(a, cr[CR_RAML_BIT]);
  assign ext_live = (region == REG_IO) && (a[2:1] == EXT_SEL);

  always_comb begin
    ws = 4'(IO_WS);
    case (region)
      REG_ROM: ws = 4'(ROM_WS);
      REG_RAM: ws = 4'(RAM_WS);
      default: ws = 4'(IO_WS);
    endcase
  end

  ws_down_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (ws - 4'd1),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

`ifdef WS_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       err_set;
`endif

  always_comb begin
    state_d  = state_q;
    n_rdy_d  = n_rdy;
    ext_d    = ext_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef WS_TIMEOUT_EN
    err_set  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          ext_d = ext_live;
          if (ws != '0) begin
            state_d  = ST_WAIT;
            cnt_load = 1'b1;
            n_rdy_d  = 1'b1;
          end else if (ext_live) begin
            state_d = ST_EXT;
            n_rdy_d = 1'b1;
          end else begin
            state_d = ST_DONE;
            n_rdy_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (!strobe) begin
          state_d = ST_IDLE;
          n_rdy_d = 1'b0;
        end else if (cnt_zero) begin
          if (ext_q) begin
            state_d = ST_EXT;
          end else begin
            state_d = ST_DONE;
            n_rdy_d = 1'b0;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_EXT: begin
        if (!strobe) begin
          state_d = ST_IDLE;
          n_rdy_d = 1'b0;
        end else if (ext_rdy) begin
          state_d = ST_DONE;
          n_rdy_d = 1'b0;
        end
`ifdef WS_TIMEOUT_EN
        else if (tcnt == 8'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          n_rdy_d = 1'b0;
          err_set = 1'b1;
        end
`endif
      end
      default: begin
        n_rdy_d = 1'b0;
        if (!strobe) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_rdy   <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_rdy   <= n_rdy_d;
      ext_q   <= ext_d;
    end
  end

`ifdef WS_TIMEOUT_EN
  // Held at zero outside EXT, so the first EXT cycle always sees 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state_q != ST_EXT) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if (err_set) begin
      bus_err <= 1'b1;
    end else if (err_clr) begin
      bus_err <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{a[7:3], a[0], cr[7:1], cnt};
`else
  assign bus_err = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{a[7:3], a[0], cr[7:1], cnt, err_clr, 8'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Directed scoreboard bench for bus_wait_ctrl with default parameters (ROM 1, RAM 0, IO 2, TIMEOUT 16).
module tb_bus_wait_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic        n_oe, n_we;
  logic [7:0]  cr;
  logic        ext_rdy, err_clr;
  logic        n_rdy, bus_err;

  typedef struct {
    string tag;
    logic  rdy;
    logic  err;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  localparam int unsigned NO = 1000;

  bus_wait_ctrl #(.ROM_WS(1), .RAM_WS(0), .IO_WS(2), .TIMEOUT(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .n_oe    (n_oe),
    .n_we    (n_we),
    .cr      (cr),
    .ext_rdy (ext_rdy),
    .err_clr (err_clr),
    .n_rdy   (n_rdy),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_now();
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (n_rdy === e.rdy && bus_err === e.err)
    else begin
      fails++;
      $error("FAIL %s: n_rdy=%b bus_err=%b, expected n_rdy=%b bus_err=%b",
             e.tag, n_rdy, bus_err, e.rdy, e.err);
    end
  endtask

  task automatic step(input string tag, input logic er, input logic ee);
    sb.push_back('{tag, er, ee});
    @(posedge clk);
    #1;
    check_now();
  endtask

  // Strobe held for h+hold edges; n_rdy expected high for the first h of them.
  // ext_rdy rises from edge index 'rise'; bus_err expected high on [err_from, err_to).
  task automatic access(input string tag, input logic [15:0] addr, input logic [7:0] crv,
                        input logic oe, input logic we, input int unsigned h,
                        input int unsigned rise, input int unsigned err_from,
                        input int unsigned err_to, input int unsigned hold,
                        input logic err_rel);
    a    = addr;
    cr   = crv;
    n_oe = oe;
    n_we = we;
    for (int unsigned i = 0; i < h + hold; i++) begin
      ext_rdy = (i >= rise);
      step(tag, (i < h), (i >= err_from) && (i < err_to));
    end
    n_oe    = 1'b1;
    n_we    = 1'b1;
    ext_rdy = 1'b0;
    step({tag, "_rel"}, 1'b0, err_rel);
    step({tag, "_idle"}, 1'b0, err_rel);
  endtask

  initial begin
    rst = 1'b1; a = '0; cr = '0; n_oe = 1'b1; n_we = 1'b1; ext_rdy = 1'b0; err_clr = 1'b0;
    #3;
    sb.push_back('{"reset", 1'b0, 1'b0});
    check_now();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    step("post_reset", 1'b0, 1'b0);

    access("rom",         16'h1234, 8'h00, 1'b0, 1'b1, 1, NO, NO, NO, 2, 1'b0);
    access("ram_low",     16'h1234, 8'h01, 1'b1, 1'b0, 0, NO, NO, NO, 3, 1'b0);
    access("rom_7fff",    16'h7FFF, 8'h00, 1'b0, 1'b1, 1, NO, NO, NO, 1, 1'b0);
    access("ram_hi_both", 16'h8000, 8'h00, 1'b0, 1'b0, 0, NO, NO, NO, 2, 1'b0);
    access("ram_feff",    16'hFEFF, 8'h00, 1'b0, 1'b1, 0, NO, NO, NO, 1, 1'b0);
    access("io_ff02",     16'hFF02, 8'h00, 1'b0, 1'b1, 2, NO, NO, NO, 2, 1'b0);
    access("io_ff00_cr1", 16'hFF00, 8'h01, 1'b1, 1'b0, 2, NO, NO, NO, 1, 1'b0);
    // 2 WAIT edges, 5 EXT edges with ext_rdy low, release on the edge sampling it high
    access("ext_ff06",    16'hFF06, 8'h00, 1'b0, 1'b1, 8, 8, NO, NO, 2, 1'b0);
    access("ext_fffe",    16'hFFFE, 8'h00, 1'b0, 1'b1, 3, 3, NO, NO, 1, 1'b0);

`ifdef WS_TIMEOUT_EN
    access("timeout", 16'hFF06, 8'h00, 1'b0, 1'b1, 18, NO, 18, NO, 2, 1'b1);
    step("err_held", 1'b0, 1'b1);
    err_clr = 1'b1;
    step("err_clr", 1'b0, 1'b0);
    err_clr = 1'b0;
    step("err_clr_after", 1'b0, 1'b0);
    err_clr = 1'b1;
    access("to_setwins", 16'hFF06, 8'h00, 1'b0, 1'b1, 18, NO, 18, 19, 2, 1'b0);
    err_clr = 1'b0;
`else
    access("ext_long", 16'hFF06, 8'h00, 1'b0, 1'b1, 23, 23, NO, NO, 1, 1'b0);
    err_clr = 1'b1;
    step("err_clr_ignored", 1'b0, 1'b0);
    err_clr = 1'b0;
`endif

    // Region/ext latched at access start; later address/cr changes must not matter
    a = 16'hFF06; cr = 8'h00; n_oe = 1'b0; ext_rdy = 1'b0;
    step("latch_0", 1'b1, 1'b0);
    a = 16'h1234; cr = 8'h01;
    for (int unsigned i = 1; i < 5; i++) step("latch_wait", 1'b1, 1'b0);
    ext_rdy = 1'b1;
    step("latch_done", 1'b0, 1'b0);
    n_oe = 1'b1; ext_rdy = 1'b0;
    step("latch_rel", 1'b0, 1'b0);

    a = 16'hFF02; cr = 8'h00; n_oe = 1'b0;
    step("abort_wait_0", 1'b1, 1'b0);
    n_oe = 1'b1;
    step("abort_wait", 1'b0, 1'b0);
    access("rom_after_abort", 16'h0100, 8'h00, 1'b0, 1'b1, 1, NO, NO, NO, 1, 1'b0);

    a = 16'hFFFE; n_oe = 1'b0; ext_rdy = 1'b0;
    for (int unsigned i = 0; i < 4; i++) step("abort_ext_wait", 1'b1, 1'b0);
    n_oe = 1'b1;
    step("abort_ext", 1'b0, 1'b0);
    step("abort_ext_idle", 1'b0, 1'b0);

    a = 16'hFF02; n_oe = 1'b0;
    step("rst_mid_0", 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    sb.push_back('{"rst_mid_async", 1'b0, 1'b0});
    check_now();
    n_oe = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    step("rst_mid_idle", 1'b0, 1'b0);
    access("rom_after_rst", 16'h0200, 8'h00, 1'b0, 1'b1, 1, NO, NO, NO, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
